exm_wb_skid_buffer: RTL and testbench

Parametrised EX/MEM→WB pipeline buffer that selects the write-back word at capture time and holds it in a two-entry skid buffer with a valid/ready handshake. It sits between the merged execute/memory stage and the register-file write port, and adds three capabilities to the fixed-width write-back register: back-pressure from write-back, synchronous flush, and a saturating stall counter.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/wb_src_mux.sv | 34 +++
 rtl/exm_wb_skid_buffer.sv | 144 ++++++++++++++
 tb/tb_exm_wb_skid_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared definitions for the EX/MEM -> WB skid buffer. It holds
//                the default widths, the write-back source selector encodings
//                and the write-back entry record.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;
    localparam int WB_N_SRC  = 4;
    localparam int WB_SEL_W  = $clog2(WB_N_SRC);
    localparam int WB_CNT_W  = 16;

    // Write-back source encodings (index into the packed source bus)
    localparam logic [WB_SEL_W-1:0] WB_SEL_EX   = 2'd0;
    localparam logic [WB_SEL_W-1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [WB_SEL_W-1:0] WB_SEL_IMM  = 2'd2;
    localparam logic [WB_SEL_W-1:0] WB_SEL_PORT = 2'd3;

    // One write-back entry at the default widths
    typedef struct packed {
        logic                 write_back;
        logic [WB_ADDR_W-1:0] write_addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_src_mux.sv
`default_nettype none
// ============================================================================
//  Module      : wb_src_mux
//  Description : Combinational N_SRC:1 write-back source selector. A selector
//                value that names no source yields an all-zero word.
//  Ports       : i_src_data [N_SRC*DATA_W] packed sources, source k at
//                                          [k*DATA_W +: DATA_W]
//                i_sel      [SEL_W]        source index
//                o_data     [DATA_W]       selected word
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_src_mux #(
    parameter int DATA_W = 16,
    parameter int N_SRC  = 4,
    parameter int SEL_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC*DATA_W-1:0] i_src_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [DATA_W-1:0]       o_data
);

    // Only an exact index match drives the output, so out-of-range
    // selectors fall through to the zero default.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_src_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule : wb_src_mux
`default_nettype wire

// File: rtl/exm_wb_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : exm_wb_skid_buffer
//  Description : EX/MEM -> WB pipeline buffer. Selects the write-back word at
//                capture time and holds up to two entries (main + skid) behind
//                a valid/ready handshake, with synchronous flush and a
//                saturating stall counter.
//  Ports       : i_clk, i_reset_n (async, active low)
//                upstream : i_src_data, i_wb_selector, i_write_back,
//                           i_write_addr, i_valid, o_ready, i_flush
//                downstream: o_valid, i_ready, o_write_back, o_write_addr,
//                           o_wb_data
//                status   : o_occupancy (0..2), o_stall_cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module exm_wb_skid_buffer
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int N_SRC  = WB_N_SRC,
    parameter int SEL_W  = $clog2(N_SRC),
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [N_SRC*DATA_W-1:0] i_src_data,
    input  logic [SEL_W-1:0]        i_wb_selector,
    input  logic                    i_write_back,
    input  logic [ADDR_W-1:0]       i_write_addr,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_write_back,
    output logic [ADDR_W-1:0]       o_write_addr,
    output logic [DATA_W-1:0]       o_wb_data,
    output logic [1:0]              o_occupancy,
    output logic [CNT_W-1:0]        o_stall_cycles
);

    typedef struct packed {
        logic              write_back;
        logic [ADDR_W-1:0] write_addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [DATA_W-1:0] w_sel_data;
    entry_t            w_new;
    entry_t            r_main_q,     w_main_d;
    entry_t            r_skid_q,     w_skid_d;
    logic              r_main_vld_q, w_main_vld_d;
    logic              r_skid_vld_q, w_skid_vld_d;
    logic              r_ready_q,    w_ready_d;
    logic [CNT_W-1:0]  r_stall_q,    w_stall_d;
    logic              w_accept;
    logic              w_pop;

    wb_src_mux #(
        .DATA_W (DATA_W),
        .N_SRC  (N_SRC),
        .SEL_W  (SEL_W)
    ) u_src_mux (
        .i_src_data (i_src_data),
        .i_sel      (i_wb_selector),
        .o_data     (w_sel_data)
    );

    assign w_accept = i_valid & r_ready_q;
    assign w_pop    = r_main_vld_q & i_ready;

    always_comb begin
        w_new.write_back = i_write_back;
        w_new.write_addr = i_write_addr;
        w_new.data       = w_sel_data;

        w_main_d     = r_main_q;
        w_skid_d     = r_skid_q;
        w_main_vld_d = r_main_vld_q;
        w_skid_vld_d = r_skid_vld_q;

        if (i_flush) begin
            // Only the valid bits are dropped; payloads stay as they were.
            w_main_vld_d = 1'b0;
            w_skid_vld_d = 1'b0;
        end else if (!r_main_vld_q) begin
            if (w_accept) begin
                w_main_d     = w_new;
                w_main_vld_d = 1'b1;
            end
        end else if (w_pop) begin
            if (r_skid_vld_q) begin
                // Skid full means o_ready is low, so nothing new arrives here.
                w_main_d     = r_skid_q;
                w_skid_vld_d = 1'b0;
            end else if (w_accept) begin
                w_main_d = w_new;
            end else begin
                w_main_vld_d = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_d     = w_new;
            w_skid_vld_d = 1'b1;
        end

        // Ready is registered from the next skid state so it never depends
        // combinationally on i_ready.
        w_ready_d = ~w_skid_vld_d;

        w_stall_d = r_stall_q;
        if (i_valid && !r_ready_q && (r_stall_q != {CNT_W{1'b1}})) begin
            w_stall_d = r_stall_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_main_q     <= '0;
            r_skid_q     <= '0;
            r_main_vld_q <= 1'b0;
            r_skid_vld_q <= 1'b0;
            r_ready_q    <= 1'b1;
            r_stall_q    <= '0;
        end else begin
            r_main_q     <= w_main_d;
            r_skid_q     <= w_skid_d;
            r_main_vld_q <= w_main_vld_d;
            r_skid_vld_q <= w_skid_vld_d;
            r_ready_q    <= w_ready_d;
            r_stall_q    <= w_stall_d;
        end
    end

    assign o_ready        = r_ready_q;
    assign o_valid        = r_main_vld_q;
    assign o_write_back   = r_main_vld_q & r_main_q.write_back;
    assign o_write_addr   = r_main_q.write_addr;
    assign o_wb_data      = r_main_q.data;
    assign o_occupancy    = {r_main_vld_q & r_skid_vld_q, r_main_vld_q ^ r_skid_vld_q};
    assign o_stall_cycles = r_stall_q;

endmodule : exm_wb_skid_buffer
`default_nettype wire

// File: tb/tb_exm_wb_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exm_wb_skid_buffer
//  Description : Self-checking bench for exm_wb_skid_buffer. A queue-based
//                reference model tracks held entries, ready and the stall
//                counters of a 16-bit and a 4-bit counter instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exm_wb_skid_buffer;
    import wb_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int N_SRC  = 4;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_SRC*DATA_W-1:0] src;
    logic [SEL_W-1:0]        sel;
    logic                    wb_in;
    logic [ADDR_W-1:0]       addr;
    logic                    valid_in;
    logic                    flush;
    logic                    ready_in;

    logic                    o_ready, o_valid, o_write_back;
    logic [ADDR_W-1:0]       o_write_addr;
    logic [DATA_W-1:0]       o_wb_data;
    logic [1:0]              o_occ;
    logic [15:0]             o_stall;

    logic                    s_ready, s_valid, s_write_back;
    logic [ADDR_W-1:0]       s_write_addr;
    logic [DATA_W-1:0]       s_wb_data;
    logic [1:0]              s_occ;
    logic [3:0]              s_stall;

    always #5 clk = ~clk;

    exm_wb_skid_buffer #(.CNT_W(16)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_src_data(src), .i_wb_selector(sel),
        .i_write_back(wb_in), .i_write_addr(addr), .i_valid(valid_in),
        .o_ready(o_ready), .i_flush(flush), .o_valid(o_valid), .i_ready(ready_in),
        .o_write_back(o_write_back), .o_write_addr(o_write_addr),
        .o_wb_data(o_wb_data), .o_occupancy(o_occ), .o_stall_cycles(o_stall)
    );

    exm_wb_skid_buffer #(.CNT_W(4)) dut_small (
        .i_clk(clk), .i_reset_n(rst_n), .i_src_data(src), .i_wb_selector(sel),
        .i_write_back(wb_in), .i_write_addr(addr), .i_valid(valid_in),
        .o_ready(s_ready), .i_flush(flush), .o_valid(s_valid), .i_ready(ready_in),
        .o_write_back(s_write_back), .o_write_addr(s_write_addr),
        .o_wb_data(s_wb_data), .o_occupancy(s_occ), .o_stall_cycles(s_stall)
    );

    // Reference model state
    typedef struct {
        logic              wb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   m_ready;
    int   m_cnt;
    int   m_cnt_s;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] pick(input logic [SEL_W-1:0] s);
        int idx;
        idx = int'(s);
        if (idx >= N_SRC) return '0;
        return src[idx*DATA_W +: DATA_W];
    endfunction

    task automatic model_reset();
        q.delete();
        m_ready = 1'b1;
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    // Apply one clock edge to the model using the inputs present at the edge.
    task automatic model_edge();
        bit   acc;
        bit   pop;
        ent_t e;
        acc = valid_in && m_ready;
        pop = (q.size() > 0) && ready_in;
        if (valid_in && !m_ready) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15)  m_cnt_s++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.wb   = wb_in;
                e.addr = addr;
                e.data = pick(sel);
                q.push_back(e);
            end
        end
        m_ready = (q.size() < 2);
    endtask

    task automatic compare_all();
        check("occupancy", 32'(o_occ), 32'(q.size()));
        check("valid", 32'(o_valid), 32'(q.size() > 0));
        check("ready", 32'(o_ready), 32'(m_ready));
        check("stall16", 32'(o_stall), 32'(m_cnt));
        check("stall4", 32'(s_stall), 32'(m_cnt_s));
        if (q.size() > 0) begin
            check("wb_data", 32'(o_wb_data), 32'(q[0].data));
            check("write_back", 32'(o_write_back), 32'(q[0].wb));
            check("write_addr", 32'(o_write_addr), 32'(q[0].addr));
        end else begin
            check("write_back_idle", 32'(o_write_back), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input bit r, input bit f,
                         input logic [SEL_W-1:0] s, input bit w, input logic [ADDR_W-1:0] a);
        valid_in = v;
        ready_in = r;
        flush    = f;
        sel      = s;
        wb_in    = w;
        addr     = a;
    endtask

    initial begin
        rst_n = 1'b0;
        src   = '0;
        drive(0, 0, 0, '0, 0, '0);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_occ", 32'(o_occ), 32'd0);
        check("rst_data", 32'(o_wb_data), 32'd0);
        check("rst_addr", 32'(o_write_addr), 32'd0);
        check("rst_wb", 32'(o_write_back), 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming through all four sources
        src = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, SEL_W'(k), 1, 3'd5);
            step();
            check("stream_data", 32'(o_wb_data), 32'h1111 * (k + 1));
            check("stream_occ", 32'(o_occ), 32'd1);
            check("stream_addr", 32'(o_write_addr), 32'd5);
        end
        drive(1, 1, 0, WB_SEL_EX, 1, 3'd5);

        // Back-pressure for three cycles, then drain
        drive(1, 0, 0, WB_SEL_MEM, 1, 3'd6);
        step();
        check("bp_ready1", 32'(o_ready), 32'd0);
        drive(1, 0, 0, WB_SEL_IMM, 1, 3'd7);
        step();
        step();
        check("bp_occ", 32'(o_occ), 32'd2);
        check("bp_stall", 32'(o_stall), 32'd2);
        drive(0, 1, 0, WB_SEL_EX, 0, 3'd0);
        step();
        check("drain_head", 32'(o_wb_data), 32'h2222);
        step();
        step();

        // Flush while two entries are held and a new one is offered
        drive(1, 0, 0, WB_SEL_PORT, 1, 3'd1);
        step();
        step();
        drive(1, 1, 1, WB_SEL_IMM, 1, 3'd2);
        step();
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_occ", 32'(o_occ), 32'd0);
        check("flush_ready", 32'(o_ready), 32'd1);
        drive(0, 1, 0, WB_SEL_EX, 0, 3'd0);
        step();

        // Non-writing entry
        drive(1, 1, 0, WB_SEL_MEM, 0, 3'd3);
        step();
        check("nowb_valid", 32'(o_valid), 32'd1);
        check("nowb_wb", 32'(o_write_back), 32'd0);
        check("nowb_data", 32'(o_wb_data), 32'h2222);
        drive(0, 1, 0, WB_SEL_EX, 0, 3'd0);
        step();

        // Asynchronous reset with two entries held
        drive(1, 0, 0, WB_SEL_IMM, 1, 3'd4);
        step();
        step();
        drive(0, 0, 0, WB_SEL_EX, 0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_occ", 32'(o_occ), 32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_stall", 32'(o_stall), 32'd0);
        check("arst_data", 32'(o_wb_data), 32'd0);
        check("arst_wb", 32'(o_write_back), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            src = {$urandom(), $urandom()};
            drive(($urandom() % 4) != 0, ($urandom() % 3) != 0, ($urandom() % 20) == 0,
                  SEL_W'($urandom()), 1'($urandom()), ADDR_W'($urandom()));
            step();
        end

        // Long stall to saturate the narrow counter
        drive(1, 0, 0, WB_SEL_PORT, 1, 3'd0);
        repeat (20) step();
        check("sat_stall4", 32'(s_stall), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_exm_wb_skid_buffer
`default_nettype wire
